cpu_debug_scanner: RTL and testbench
====================================

# cpu_debug_scanner

Debug-side master for the pipeline CPU's observation ports. It drives the CPU's `rf_addr` and `mem_addr` inputs and samples `rf_data`, `mem_data`, the five stage PCs and HI/LO. On each `start` pulse it emits one dump frame as a stream of tagged 32-bit words over a valid/ready handshake, toward a UART/host bridge. It sits beside `pipeline_cpu` in the board top and never stalls or modifies the CPU.

## Interface
Parameters:
- `MEM_BASE`, 32'h0000_0000, byte address of the first memory word dumped.
- `MEM_WORDS`, 16, number of memory words dumped; legal range 1..192.
- `RD_LAT`, 1, cycles from address change to valid read data at the CPU debug port; legal range 0..3.

Ports:
- `clk` in 1: the single clock; all logic on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a dump; ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` until the last word handshakes.
- `rf_addr` out 5: register-file read address to the CPU.
- `mem_addr` out 32: data-memory read address to the CPU.
- `rf_data` in 32, `mem_data` in 32: read data from the CPU.
- `IF_pc`, `ID_pc`, `EXE_pc`, `MEM_pc`, `WB_pc` in 32 each: stage PCs.
- `HI_data`, `LO_data` in 32: multiplier HI/LO.
- `out_valid` out 1, `out_ready` in 1: stream handshake.
- `out_data` out 32: word payload.
- `out_tag` out 8: word identity.
- `out_last` out 1: high with the final word of a frame.

## Operation
- States: IDLE, SNAP, ADDR, SEND, plus a wait counter of 2 bits.
- IDLE, `start`=1: capture all five PCs, HI and LO into snapshot registers on that edge, clear the index, set `busy`, and go to SNAP.
- SNAP: present snapshot words in this order. Tag 0x30..0x34 carries IF, ID, EXE, MEM, WB PC. Tag 0x20 carries HI and tag 0x21 carries LO. Each word advances on handshake. After LO, go to ADDR for register 0.
- ADDR: drive the address and hold it for RD_LAT+1 cycles. On the edge ending the last cycle, latch the data into `out_data`, then go to SEND.
  - Registers: `rf_addr`=i for i=0..31; tag = i.
  - Memory: `mem_addr` = `MEM_BASE` + 4·k for k=0..MEM_WORDS-1; tag = 0x40+k. Address arithmetic is modulo 2^32 and wraps silently.
- SEND: `out_valid`=1. `out_data`, `out_tag` and `out_last` stay stable until `out_ready`=1.
  - On handshake, advance to the next address and return to ADDR.
  - After the final word, go to IDLE.
- Frame length is 7+32+MEM_WORDS words. `out_last` is high only on memory word MEM_WORDS-1.
- `rf_addr` holds the last register index during the memory phase. `mem_addr` holds its last value after the frame.
- `start` while `busy` is dropped, not queued.

## Timing
- Reset values: `busy`=0, `out_valid`=0, `out_data`=0, `out_tag`=0, `out_last`=0, `rf_addr`=0, `mem_addr`=`MEM_BASE`, state IDLE.
- `start` sampled at edge N: `busy`=1 and `out_valid`=1 with tag 0x30 from cycle N+1. The snapshot is the value present at edge N.
- With `out_ready` held at 1:
  - Snapshot words take 1 cycle each.
  - Register and memory words take RD_LAT+2 cycles each (RD_LAT+1 in ADDR, 1 in SEND).
- `busy` falls on the cycle after the `out_last` handshake. `start` is accepted again in that same cycle.
- Reset mid-frame aborts immediately and asynchronously to the reset values. No partial word or `out_last` is emitted.
- `out_valid` never drops without a handshake.

## Configuration
- `DBG_SCAN_PC_EN` defined: SNAP phase present; frame as above.
- `DBG_SCAN_PC_EN` undefined: SNAP phase and snapshot registers are removed.
  - `start` goes directly to ADDR for register 0; first `out_valid` at N+RD_LAT+2.
  - Frame length is 32+MEM_WORDS; tags 0x20/0x21/0x30..0x34 never appear.
  - PC/HI/LO ports remain and are unused.

## Test plan
- Model the CPU port as regfile[i]=0x1000_0000+i and mem[a]=~a, with RD_LAT=1, MEM_WORDS=4, MEM_BASE=0x100 and `out_ready`=1. One `start` -> 43 words.
  - Tags 0x30..0x34, 0x20, 0x21, 0x00..0x1F, 0x40..0x43 in order.
  - Word for tag 0x05 = 0x1000_0005; tag 0x42 = ~32'h108.
  - `out_last` only on 0x43; `busy` low one cycle later.
- Set PCs to 0x400..0x410 at the `start` edge, then change them next cycle -> words 0x30..0x34 still carry 0x400..0x410.
- Drive `out_ready` low for 5 cycles on tag 0x07 -> `out_data`/`out_tag` stable for all 5 cycles; no word lost or duplicated.
- Pulse `start` at the word with tag 0x10 -> ignored; exactly one 43-word frame.
- Assert `resetn`=0 during tag 0x40 -> all outputs at reset values at once; a fresh `start` yields a full frame beginning at 0x30.
- MEM_BASE=0xFFFF_FFF8, MEM_WORDS=4 -> `mem_addr` sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4.

Source files
------------

// File: rtl/cpu_debug_scanner_if.sv
// Output stream of the debug scanner: tagged 32-bit words with
// valid/ready flow control and an end-of-frame marker.
interface cpu_debug_scanner_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_tag;
    logic        out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_tag,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_tag,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/cpu_debug_scanner.sv
// Debug dump master: walks regfile and data memory of the CPU and streams
// tagged words. Define DBG_SCAN_PC_EN to prepend a PC/HI/LO snapshot.
module cpu_debug_scanner #(
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter int          MEM_WORDS = 16,
    parameter int          RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic        busy,
    output logic [4:0]  rf_addr,
    output logic [31:0] mem_addr,
    input  logic [31:0] rf_data,
    input  logic [31:0] mem_data,
    input  logic [31:0] IF_pc,
    input  logic [31:0] ID_pc,
    input  logic [31:0] EXE_pc,
    input  logic [31:0] MEM_pc,
    input  logic [31:0] WB_pc,
    input  logic [31:0] HI_data,
    input  logic [31:0] LO_data,
    cpu_debug_scanner_if.master stream
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SNAP = 2'd1;
    localparam logic [1:0] S_ADDR = 2'd2;
    localparam logic [1:0] S_SEND = 2'd3;

    localparam logic [7:0] LAST_IDX = 8'(32 + MEM_WORDS - 1);
    localparam logic [1:0] WAIT_END = 2'(RD_LAT);

    logic [1:0]  state;
    logic [1:0]  wcnt;
    logic [7:0]  widx;
    logic [7:0]  nidx;
    logic        in_mem;
    logic        hs;
    logic        valid_q;
    logic        last_q;
    logic [31:0] data_q;
    logic [7:0]  tag_q;

    assign nidx   = widx + 8'd1;
    assign in_mem = (widx >= 8'd32);
    assign hs     = valid_q & stream.out_ready;

    assign stream.out_valid = valid_q;
    assign stream.out_data  = data_q;
    assign stream.out_tag   = tag_q;
    assign stream.out_last  = last_q;

`ifdef DBG_SCAN_PC_EN
    logic [2:0]  sidx;
    logic [31:0] snap [0:5];

    // Words 0..4 are stage PCs (0x30..0x34), 5 and 6 are HI/LO (0x20/0x21)
    function automatic logic [7:0] snap_tag(input logic [2:0] j);
        if (j < 3'd5)
            return 8'h30 + {5'd0, j};
        return 8'h1B + {5'd0, j};
    endfunction
`else
    logic unused_snap;
    assign unused_snap = ^{IF_pc, ID_pc, EXE_pc, MEM_pc, WB_pc,
                           HI_data, LO_data};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            wcnt     <= 2'd0;
            widx     <= 8'd0;
            busy     <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= 32'd0;
            tag_q    <= 8'd0;
            rf_addr  <= 5'd0;
            mem_addr <= MEM_BASE;
`ifdef DBG_SCAN_PC_EN
            sidx     <= 3'd0;
            for (int i = 0; i < 6; i++)
                snap[i] <= 32'd0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        widx <= 8'd0;
                        wcnt <= 2'd0;
`ifdef DBG_SCAN_PC_EN
                        snap[0] <= ID_pc;
                        snap[1] <= EXE_pc;
                        snap[2] <= MEM_pc;
                        snap[3] <= WB_pc;
                        snap[4] <= HI_data;
                        snap[5] <= LO_data;
                        sidx    <= 3'd0;
                        data_q  <= IF_pc;
                        tag_q   <= 8'h30;
                        valid_q <= 1'b1;
                        state   <= S_SNAP;
`else
                        rf_addr <= 5'd0;
                        state   <= S_ADDR;
`endif
                    end
                end
                S_SNAP: begin
`ifdef DBG_SCAN_PC_EN
                    if (hs) begin
                        if (sidx == 3'd6) begin
                            valid_q <= 1'b0;
                            rf_addr <= 5'd0;
                            wcnt    <= 2'd0;
                            state   <= S_ADDR;
                        end else begin
                            sidx   <= sidx + 3'd1;
                            data_q <= snap[sidx];
                            tag_q  <= snap_tag(sidx + 3'd1);
                        end
                    end
`else
                    state <= S_IDLE;
`endif
                end
                S_ADDR: begin
                    // Hold the address RD_LAT+1 cycles, sample on the last
                    if (wcnt == WAIT_END) begin
                        data_q  <= in_mem ? mem_data : rf_data;
                        tag_q   <= in_mem ? widx + 8'h20 : widx;
                        last_q  <= (widx == LAST_IDX);
                        valid_q <= 1'b1;
                        state   <= S_SEND;
                    end else begin
                        wcnt <= wcnt + 2'd1;
                    end
                end
                S_SEND: begin
                    if (hs) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        wcnt    <= 2'd0;
                        if (widx == LAST_IDX) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            widx  <= nidx;
                            state <= S_ADDR;
                            if (nidx < 8'd32)
                                rf_addr <= nidx[4:0];
                            else if (nidx == 8'd32)
                                mem_addr <= MEM_BASE;
                            else
                                mem_addr <= mem_addr + 32'd4;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_debug_scanner.sv
// Scoreboard bench for cpu_debug_scanner: directed frames, back-pressure,
// dropped start, mid-frame reset and memory address wrap.
module tb_cpu_debug_scanner;
    localparam int          RD_LAT    = 1;
    localparam int          MEM_WORDS = 4;
    localparam logic [31:0] MEM_BASE  = 32'h0000_0100;
`ifdef DBG_SCAN_PC_EN
    localparam bit PC_EN = 1'b1;
`else
    localparam bit PC_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0]  tag;
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic [4:0]  rf_addr;
    logic [31:0] mem_addr;
    logic [31:0] rf_data = 32'd0;
    logic [31:0] mem_data = 32'd0;
    logic [31:0] IF_pc = 32'd0, ID_pc = 32'd0, EXE_pc = 32'd0;
    logic [31:0] MEM_pc = 32'd0, WB_pc = 32'd0;
    logic [31:0] HI_data = 32'd0, LO_data = 32'd0;

    logic        start2 = 1'b0;
    logic        busy2;
    logic [4:0]  rf_addr2;
    logic [31:0] mem_addr2;
    logic [31:0] rf_data2 = 32'd0;
    logic [31:0] mem_data2 = 32'd0;

    cpu_debug_scanner_if sif ();
    cpu_debug_scanner_if sif2 ();

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t e_m;
    int   stall_cnt = 0;
    int   k2 = 0;

    cpu_debug_scanner #(
        .MEM_BASE(MEM_BASE), .MEM_WORDS(MEM_WORDS), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .busy(busy),
        .rf_addr(rf_addr), .mem_addr(mem_addr),
        .rf_data(rf_data), .mem_data(mem_data),
        .IF_pc(IF_pc), .ID_pc(ID_pc), .EXE_pc(EXE_pc),
        .MEM_pc(MEM_pc), .WB_pc(WB_pc),
        .HI_data(HI_data), .LO_data(LO_data),
        .stream(sif)
    );

    cpu_debug_scanner #(
        .MEM_BASE(32'hFFFF_FFF8), .MEM_WORDS(4), .RD_LAT(RD_LAT)
    ) dut2 (
        .clk(clk), .resetn(resetn), .start(start2), .busy(busy2),
        .rf_addr(rf_addr2), .mem_addr(mem_addr2),
        .rf_data(rf_data2), .mem_data(mem_data2),
        .IF_pc(IF_pc), .ID_pc(ID_pc), .EXE_pc(EXE_pc),
        .MEM_pc(MEM_pc), .WB_pc(WB_pc),
        .HI_data(HI_data), .LO_data(LO_data),
        .stream(sif2)
    );

    always #5 clk = ~clk;

    // CPU debug port model with one cycle of read latency
    always @(posedge clk) begin
        rf_data   <= 32'h1000_0000 + {27'd0, rf_addr};
        mem_data  <= ~mem_addr;
        rf_data2  <= 32'h1000_0000 + {27'd0, rf_addr2};
        mem_data2 <= ~mem_addr2;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_frame(input logic [31:0] pc0,
                              input logic [31:0] hi,
                              input logic [31:0] lo);
        if (PC_EN) begin
            for (int j = 0; j < 5; j++)
                q.push_back('{8'h30 + 8'(j), pc0 + 32'(4 * j), 1'b0});
            q.push_back('{8'h20, hi, 1'b0});
            q.push_back('{8'h21, lo, 1'b0});
        end
        for (int i = 0; i < 32; i++)
            q.push_back('{8'(i), 32'h1000_0000 + 32'(i), 1'b0});
        for (int k = 0; k < MEM_WORDS; k++)
            q.push_back('{8'h40 + 8'(k), ~(MEM_BASE + 32'(4 * k)),
                          k == MEM_WORDS - 1});
    endtask

    // Scoreboard monitor, samples on the falling edge
    bit         holding = 0;
    bit         busy_chk = 0;
    logic [7:0]  h_tag;
    logic [31:0] h_data;
    logic        h_last;

    always @(negedge clk) begin
        if (!resetn) begin
            holding  = 0;
            busy_chk = 0;
        end else begin
            if (busy_chk) begin
                chk("busy_fall", {31'd0, busy}, 32'd0);
                busy_chk = 0;
            end
            if (holding) begin
                chk("hold_valid", {31'd0, sif.out_valid}, 32'd1);
                chk("hold_tag", {24'd0, sif.out_tag}, {24'd0, h_tag});
                chk("hold_data", sif.out_data, h_data);
                chk("hold_last", {31'd0, sif.out_last}, {31'd0, h_last});
            end
            holding = 0;
            if (sif.out_valid) begin
                if (sif.out_ready) begin
                    n_chk++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_word: got tag %h data %h expected none",
                                 sif.out_tag, sif.out_data);
                    end else begin
                        e_m = q.pop_front();
                        chk("word_tag", {24'd0, sif.out_tag}, {24'd0, e_m.tag});
                        chk("word_data", sif.out_data, e_m.data);
                        chk("word_last", {31'd0, sif.out_last}, {31'd0, e_m.last});
                        if (e_m.last) begin
                            chk("busy_at_last", {31'd0, busy}, 32'd1);
                            busy_chk = 1;
                        end
                    end
                end else begin
                    holding = 1;
                    h_tag   = sif.out_tag;
                    h_data  = sif.out_data;
                    h_last  = sif.out_last;
                    stall_cnt++;
                end
            end
        end
    end

    // Wrap-around instance: check addresses and data of the memory words
    logic [31:0] wrap_addr [0:3];
    initial begin
        wrap_addr[0] = 32'hFFFF_FFF8;
        wrap_addr[1] = 32'hFFFF_FFFC;
        wrap_addr[2] = 32'h0000_0000;
        wrap_addr[3] = 32'h0000_0004;
    end

    always @(negedge clk) begin
        if (resetn && sif2.out_valid && sif2.out_tag >= 8'h40) begin
            if (k2 < 4) begin
                chk("wrap_addr", mem_addr2, wrap_addr[k2]);
                chk("wrap_data", sif2.out_data, ~wrap_addr[k2]);
            end
            k2++;
        end
    end

    task automatic do_start(input logic [31:0] pc0, input logic [31:0] hi,
                            input logic [31:0] lo);
        int lat;
        push_frame(pc0, hi, lo);
        @(posedge clk); #1;
        start   = 1'b1;
        IF_pc   = pc0;
        ID_pc   = pc0 + 32'd4;
        EXE_pc  = pc0 + 32'd8;
        MEM_pc  = pc0 + 32'd12;
        WB_pc   = pc0 + 32'd16;
        HI_data = hi;
        LO_data = lo;
        @(posedge clk); #1;
        start   = 1'b0;
        IF_pc   = 32'hDEAD_0000;
        ID_pc   = 32'hDEAD_0001;
        EXE_pc  = 32'hDEAD_0002;
        MEM_pc  = 32'hDEAD_0003;
        WB_pc   = 32'hDEAD_0004;
        HI_data = 32'hDEAD_0005;
        LO_data = 32'hDEAD_0006;
        chk("busy_rise", {31'd0, busy}, 32'd1);
        lat = 1;
        while (!sif.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("first_valid_lat", 32'(lat), PC_EN ? 32'd1 : 32'(RD_LAT + 2));
    endtask

    task automatic wait_tag(input logic [7:0] t);
        int n;
        n = 0;
        while (!(sif.out_valid && sif.out_tag == t) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_tag: got timeout expected tag %h", t);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: got busy expected idle");
        end
    endtask

    task automatic chk_reset_vals(input string tag_s);
        chk({tag_s, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag_s, "_valid"}, {31'd0, sif.out_valid}, 32'd0);
        chk({tag_s, "_data"}, sif.out_data, 32'd0);
        chk({tag_s, "_tag"}, {24'd0, sif.out_tag}, 32'd0);
        chk({tag_s, "_last"}, {31'd0, sif.out_last}, 32'd0);
        chk({tag_s, "_rf_addr"}, {27'd0, rf_addr}, 32'd0);
        chk({tag_s, "_mem_addr"}, mem_addr, MEM_BASE);
    endtask

    initial begin
        int n;
        sif.out_ready  = 1'b1;
        sif2.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        resetn = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("post_rst");

        // Memory address wrap on the second instance
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 0;
        while (!busy2 && n < 10) begin @(posedge clk); #1; n++; end
        while (busy2 && n < 3000) begin @(posedge clk); #1; n++; end
        chk("wrap_count", 32'(k2), 32'd4);

        // Plain frame with snapshot PCs changing right after start
        do_start(32'h0000_0400, 32'hAAAA_0001, 32'h5555_0002);
        wait_tag(8'h05);
        chk("reg5_data", sif.out_data, 32'h1000_0005);
        wait_tag(8'h42);
        chk("mem2_data", sif.out_data, ~32'h0000_0108);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("frame1_drained", 32'(q.size()), 32'd0);

        // Back-pressure on tag 0x07, ignored start on tag 0x10
        do_start(32'h0000_0800, 32'h1234_5678, 32'h8765_4321);
        wait_tag(8'h07);
        stall_cnt = 0;
        sif.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        sif.out_ready = 1'b1;
        chk("stall_cycles", 32'(stall_cnt), 32'd5);
        wait_tag(8'h10);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        repeat (20) @(posedge clk);
        #1;
        chk("no_second_frame", {31'd0, busy}, 32'd0);
        chk("frame2_drained", 32'(q.size()), 32'd0);

        // Reset in the middle of the memory phase
        do_start(32'h0000_0C00, 32'h0000_00AA, 32'h0000_00BB);
        wait_tag(8'h40);
        resetn = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        do_start(32'h0000_1000, 32'h0000_0011, 32'h0000_0022);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("frame3_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
